amber_interval_timer: RTL and testbench

Responder end of the amber-timer handshake. Accepts a level request from the traffic-light controller, times a programmable number of seconds, then returns a held done pulse and waits for the request to be released. Replaces the free-running timer with a start/busy/done protocol, and exposes sub-second and second counters for debugging.

---
 rtl/amber_interval_timer_pkg.sv | 16 +
 rtl/amber_interval_timer_if.sv | 22 ++
 rtl/amber_interval_timer_tick_prescaler.sv | 40 ++++
 rtl/amber_interval_timer.sv | 153 +++++++++++++++
 tb/tb_amber_interval_timer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/amber_interval_timer_pkg.sv
// Shared types and constants for the amber interval timer.
// Contents: FSM state enum, counter widths, default duration.
package traffic_pkg;

    localparam int unsigned SEC_W           = 4;
    localparam int unsigned SUB_W           = 3;
    localparam int unsigned DEFAULT_SECONDS = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/amber_interval_timer_if.sv
// Amber-timer handshake between traffic-light controller (master) and timer (slave).
// Signals: req, duration_s (master -> slave); busy, done, sub_seconds, seconds (slave -> master).
interface amber_interval_timer_if;

    logic                            req;
    logic [traffic_pkg::SEC_W-1:0]   duration_s;
    logic                            busy;
    logic                            done;
    logic [traffic_pkg::SUB_W-1:0]   sub_seconds;
    logic [traffic_pkg::SEC_W-1:0]   seconds;

    modport master (
        output req, duration_s,
        input  busy, done, sub_seconds, seconds
    );

    modport slave (
        input  req, duration_s,
        output busy, done, sub_seconds, seconds
    );

endinterface

// File: rtl/amber_interval_timer_tick_prescaler.sv
// Sub-second prescaler: counts 0..TICKS_PER_SUB-1 while enabled, pulses tick on terminal count.
// Ports: clk, rst (async, active-high), clear (sync zero), enable (count), tick (comb pulse).
module tick_prescaler #(
    parameter int unsigned TICKS_PER_SUB = 6250000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (TICKS_PER_SUB > 1) ? $clog2(TICKS_PER_SUB) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_c;

    assign last_c = (cnt_q == CNT_W'(TICKS_PER_SUB - 1));

    // Tick is combinational so the parent counters advance on the same edge the prescaler wraps.
    assign tick = enable && !clear && last_c;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = last_c ? '0 : CNT_W'(cnt_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/amber_interval_timer.sv
// Amber interval timer: responder end of the req/busy/done handshake. Times a latched number
// of seconds, holds done for DONE_HOLD cycles, then waits for req release before re-arming.
// Ports: clk, rst (async, active-high), bus (slave modport: req, duration_s in;
//        busy, done, sub_seconds, seconds out, all registered).
// Build option: REQ_DROP_ABORT_EN -- when defined, req low during RUN aborts to IDLE.
module amber_interval_timer
    import traffic_pkg::*;
#(
    parameter int unsigned TICKS_PER_SUB   = 6250000,
    parameter int unsigned SUBS_PER_SEC    = 8,
    parameter int unsigned DONE_HOLD       = 4,
    parameter int unsigned DEFAULT_SECONDS = traffic_pkg::DEFAULT_SECONDS
) (
    input  logic                   clk,
    input  logic                   rst,
    amber_interval_timer_if.slave  bus
);

    localparam int unsigned HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

    state_t              state_q, state_d;
    logic [SEC_W-1:0]    dur_q, dur_d;
    logic [SEC_W-1:0]    sec_q, sec_d;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                tick;
    logic                sub_last_c;
    logic                expire_c;
    logic                hold_last_c;

    tick_prescaler #(
        .TICKS_PER_SUB (TICKS_PER_SUB)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != RUN),
        .enable (state_q == RUN),
        .tick   (tick)
    );

    assign sub_last_c  = (sub_q == SUB_W'(SUBS_PER_SEC - 1));
    // Expiry is the tick on which seconds would step up to the latched duration.
    assign expire_c    = tick && sub_last_c && (SEC_W'(sec_q + SEC_W'(1)) == dur_q);
    assign hold_last_c = (hold_q == HOLD_W'(DONE_HOLD - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req) state_d = RUN;
            end
            RUN: begin
                if (expire_c) begin
                    state_d = DONE;
                end
`ifdef REQ_DROP_ABORT_EN
                else if (!bus.req) begin
                    state_d = IDLE;
                end
`endif
            end
            DONE: begin
                if (hold_last_c) state_d = RELEASE;
            end
            RELEASE: begin
                if (!bus.req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and counter next values; outputs follow the next state so they are registered Moore.
    always_comb begin
        dur_d  = dur_q;
        sec_d  = sec_q;
        sub_d  = sub_q;
        hold_d = hold_q;
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    dur_d  = (bus.duration_s == '0) ? SEC_W'(DEFAULT_SECONDS) : bus.duration_s;
                    sec_d  = '0;
                    sub_d  = '0;
                    hold_d = '0;
                end
            end
            RUN: begin
                hold_d = '0;
                if (state_d == IDLE) begin
                    sec_d = '0;
                    sub_d = '0;
                end else if (tick) begin
                    if (sub_last_c) begin
                        sub_d = '0;
                        sec_d = SEC_W'(sec_q + SEC_W'(1));
                    end else begin
                        sub_d = SUB_W'(sub_q + SUB_W'(1));
                    end
                end
            end
            DONE: begin
                if (!hold_last_c) hold_d = HOLD_W'(hold_q + HOLD_W'(1));
            end
            RELEASE: begin
                if (state_d == IDLE) begin
                    sec_d = '0;
                    sub_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dur_q  <= '0;
            sec_q  <= '0;
            sub_q  <= '0;
            hold_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dur_q  <= dur_d;
            sec_q  <= sec_d;
            sub_q  <= sub_d;
            hold_q <= hold_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.sub_seconds = sub_q;
    assign bus.seconds     = sec_q;

endmodule

// File: tb/tb_amber_interval_timer.sv
// Bench for amber_interval_timer with TICKS_PER_SUB=2, SUBS_PER_SEC=4, DONE_HOLD=4
// (8 cycles per second). Stimulus pushes the expected done event; a negedge monitor
// pops and compares whenever done rises.
module tb_amber_interval_timer;

    typedef struct {
        int         cyc;
        logic [3:0] sec;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t e;
    int   hi_len;
    logic done_prev;

    amber_interval_timer_if bus();

    amber_interval_timer #(
        .TICKS_PER_SUB   (2),
        .SUBS_PER_SEC    (4),
        .DONE_HOLD       (4),
        .DEFAULT_SECONDS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    // Issue a request from a negedge; returns at the negedge after the acceptance edge.
    task automatic start_timing(input logic [3:0] d, input logic [3:0] eff);
        exp_t x;
        x.cyc = cyc + 1 + int'(eff) * 8;
        x.sec = eff;
        exp_q.push_back(x);
        bus.duration_s = d;
        bus.req        = 1'b1;
        @(negedge clk);
        check("busy_after_accept", bus.busy, 1);
    endtask

    // Scoreboard monitor: compares each done pulse against the queued expectation.
    initial begin
        done_prev = 1'b0;
        hi_len    = 0;
    end
    always @(negedge clk) begin
        if (bus.done && !done_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_seconds", bus.seconds, e.sec);
                check("done_sub", bus.sub_seconds, 0);
                check("busy_in_done", bus.busy, 0);
            end
            hi_len = 0;
        end
        if (bus.done) hi_len++;
        if (!bus.done && done_prev) check("done_width", hi_len, 4);
        done_prev = bus.done;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.req        = 1'b0;
        bus.duration_s = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sub", bus.sub_seconds, 0);
        check("rst_seconds", bus.seconds, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic timing with retrigger guard: req held through DONE and beyond.
        start_timing(4'd2, 4'd2);
        repeat (20) @(negedge clk);
        check("release_busy", bus.busy, 0);
        check("release_done", bus.done, 0);
        check("release_seconds", bus.seconds, 2);
        check("release_sub", bus.sub_seconds, 0);
        repeat (5) @(negedge clk);
        check("held_req_no_retrigger_busy", bus.busy, 0);
        check("held_req_no_retrigger_sec", bus.seconds, 2);
        bus.req = 1'b0;
        @(negedge clk);
        check("idle_seconds_cleared", bus.seconds, 0);
        check("idle_busy", bus.busy, 0);

        // Default duration.
        start_timing(4'd0, 4'd3);
        repeat (28) @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("default_idle_seconds", bus.seconds, 0);

        // Asynchronous reset mid-run aborts without done.
        start_timing(4'd5, 4'd5);
        repeat (4) @(negedge clk);
        check("pre_reset_sub", bus.sub_seconds, 2);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("midrun_rst_busy", bus.busy, 0);
        check("midrun_rst_done", bus.done, 0);
        check("midrun_rst_sub", bus.sub_seconds, 0);
        check("midrun_rst_seconds", bus.seconds, 0);
        @(negedge clk);
        bus.req = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        start_timing(4'd1, 4'd1);
        repeat (12) @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);

        // duration_s changes during RUN are ignored.
        start_timing(4'd1, 4'd1);
        bus.duration_s = 4'd9;
        repeat (12) @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("sampling_idle_seconds", bus.seconds, 0);

        // req drop at RUN cycle 6.
        start_timing(4'd1, 4'd1);
`ifdef REQ_DROP_ABORT_EN
        void'(exp_q.pop_back());
`endif
        repeat (5) @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
`ifdef REQ_DROP_ABORT_EN
        check("abort_busy", bus.busy, 0);
        check("abort_seconds", bus.seconds, 0);
`else
        check("no_abort_busy", bus.busy, 1);
`endif
        repeat (10) @(negedge clk);
        check("after_drop_busy", bus.busy, 0);
        check("after_drop_seconds", bus.seconds, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
